// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder: word RAM plus MMIO page, combinational loads, sticky fault status
module dm_responder #(
    parameter int          AW        = 10,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic        mem_r,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic [2:0]  dmtype,
    output logic [31:0] dout,
    output logic        misalign,
    output logic [15:0] led
);

    localparam int RAM_WORDS = 1 << AW;

    logic [31:0] ram [RAM_WORDS];
    logic [31:0] cycle;
    logic [31:0] fault_addr;
    logic [2:0]  status;

    logic        access;
    logic        ram_hit;
    logic        mmio_hit;
    logic        legal;
    logic        is_half;
    logic        is_word;
    logic        mis_c;
    logic        oor_c;
    logic        rwc_c;
    logic        fault;
    logic        store_ok;
    logic [2:0]  new_bits;
    logic [2:0]  clr_bits;
    logic [31:0] ram_word;
    logic [31:0] mmio_word;
    logic [31:0] raw;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext;
    logic [31:0] wdata;
    logic [3:0]  be;

    always_comb begin
        access   = mem_w | mem_r;
        ram_hit  = (addr[31:AW+2] == '0);
        mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
        legal    = (dmtype == 3'b000) || (dmtype == 3'b001) || (dmtype == 3'b010) ||
                   (dmtype == 3'b100) || (dmtype == 3'b101);
        is_half  = (dmtype[1:0] == 2'b01);
        is_word  = (dmtype == 3'b010);
        // MMIO registers are only reachable with aligned word accesses
        mis_c    = !legal || (is_half && addr[0]) || (is_word && addr[1:0] != 2'b00) ||
                   (mmio_hit && !is_word);
        oor_c    = !ram_hit && !mmio_hit;
        rwc_c    = mem_w & mem_r;
        fault    = mis_c | oor_c;
        misalign = !reset && access && fault;
        new_bits = access ? {rwc_c, oor_c, mis_c} : 3'b000;
        store_ok = !reset && mem_w && !fault;
        clr_bits = (store_ok && mmio_hit && addr[3:2] == 2'b10) ? din[2:0] : 3'b000;
    end

    always_comb begin
        ram_word = ram[addr[AW+1:2]];
        case (addr[3:2])
            2'b00:   mmio_word = {16'b0, led};
            2'b01:   mmio_word = cycle;
            2'b10:   mmio_word = {29'b0, status};
            default: mmio_word = fault_addr;
        endcase
        raw      = ram_hit ? ram_word : mmio_word;
        sel_byte = raw[{addr[1:0], 3'b000} +: 8];
        sel_half = addr[1] ? raw[31:16] : raw[15:0];
        case (dmtype)
            3'b000:  ext = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ext = {24'b0, sel_byte};
            3'b001:  ext = {{16{sel_half[15]}}, sel_half};
            3'b101:  ext = {16'b0, sel_half};
            3'b010:  ext = raw;
            default: ext = 32'b0;
        endcase
        dout = (!reset && mem_r && !mem_w && !fault) ? ext : 32'b0;
    end

    // Store data is replicated across lanes so each byte enable just picks its own slice
    always_comb begin
        if (is_word) begin
            wdata = din;
            be    = 4'b1111;
        end else if (is_half) begin
            wdata = {2{din[15:0]}};
            be    = addr[1] ? 4'b1100 : 4'b0011;
        end else begin
            wdata = {4{din[7:0]}};
            be    = 4'b0001 << addr[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (store_ok && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[addr[AW+1:2]][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led        <= 16'b0;
            cycle      <= 32'b0;
            status     <= 3'b000;
            fault_addr <= 32'b0;
        end else begin
            cycle <= cycle + 32'd1;
            if (store_ok && mmio_hit && addr[3:2] == 2'b00) led <= din[15:0];
            // New faults win over a simultaneous write-1-to-clear
            status <= (status & ~clr_bits) | new_bits;
            if (status == 3'b000 && new_bits != 3'b000) fault_addr <= addr;
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder against a byte-level memory model
module tb_dm_responder;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_w = 1'b0;
    logic        mem_r = 1'b0;
    logic [31:0] addr = 32'b0;
    logic [31:0] din = 32'b0;
    logic [2:0]  dmtype = 3'b0;
    logic [31:0] dout;
    logic        misalign;
    logic [15:0] led;

    dm_responder #(.AW(10), .MMIO_BASE(BASE)) dut (
        .clk(clk), .reset(reset), .mem_w(mem_w), .mem_r(mem_r), .addr(addr),
        .din(din), .dmtype(dmtype), .dout(dout), .misalign(misalign), .led(led)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        m;
        logic [15:0] l;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    byte unsigned mem [4096];
    logic [15:0]  m_led = 16'b0;
    logic [2:0]   m_st = 3'b0;
    logic [31:0]  m_fa = 32'b0;
    logic [31:0]  edges = 32'b0;
    logic [31:0]  cyc_adj = 32'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 32'b0;
        else       edges <= edges + 32'd1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk({e.nm, " dout"}, dout, e.d);
            chk({e.nm, " misalign"}, {31'b0, misalign}, {31'b0, e.m});
            chk({e.nm, " led"}, {16'b0, led}, {16'b0, e.l});
        end
    end

    // Drives one access for a cycle, predicts the response, then applies the access to the model
    task automatic do_access(input logic mw, input logic mr, input logic [31:0] a,
                             input logic [31:0] d, input logic [2:0] t, input string nm,
                             input bit lit = 0, input logic [31:0] ld = 0, input logic lm = 0);
        int          sz;
        bit          legal, rm, mm, mis, oor, flt;
        logic [31:0] v;
        logic [2:0]  nb, clr;
        exp_t        e;
        @(posedge clk);
        #1;
        mem_w = mw; mem_r = mr; addr = a; din = d; dmtype = t;
        legal = (t == 3'd0) || (t == 3'd1) || (t == 3'd2) || (t == 3'd4) || (t == 3'd5);
        sz  = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
        rm  = a < 32'd4096;
        mm  = (a >= BASE) && (a < BASE + 32'd16);
        mis = !legal || (a % 32'(sz)) != 0 || (mm && sz != 4);
        oor = !rm && !mm;
        flt = mis || oor;
        v = 32'b0;
        if (mr && !mw && !flt) begin
            if (rm) begin
                for (int i = 0; i < sz; i++) v = v | (32'(mem[a + 32'(i)]) << (8 * i));
            end else begin
                case (a - BASE)
                    32'd0:   v = {16'b0, m_led};
                    32'd4:   v = edges + cyc_adj;
                    32'd8:   v = {29'b0, m_st};
                    default: v = m_fa;
                endcase
            end
            if (t[2] == 1'b0 && sz < 4 && v[8 * sz - 1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
        end
        e.d  = lit ? ld : v;
        e.m  = lit ? lm : ((mw || mr) && flt);
        e.l  = m_led;
        e.nm = nm;
        sbq.push_back(e);
        nb  = (mw || mr) ? {mw && mr, oor, mis} : 3'b0;
        clr = 3'b0;
        if (mw && !flt) begin
            if (rm) begin
                for (int i = 0; i < sz; i++) mem[a + 32'(i)] = d[8 * i +: 8];
            end else if (a - BASE == 32'd0) begin
                m_led = d[15:0];
            end else if (a - BASE == 32'd8) begin
                clr = d[2:0];
            end
        end
        if (m_st == 3'b0 && nb != 3'b0) m_fa = a;
        m_st = (m_st & ~clr) | nb;
    endtask

    initial begin
        exp_t e;
        int   r;
        logic [2:0] legal_t [5];
        logic [31:0] a;
        legal_t[0] = 3'd0; legal_t[1] = 3'd1; legal_t[2] = 3'd2; legal_t[3] = 3'd4; legal_t[4] = 3'd5;

        // Reset state, with a load pending to show outputs are forced quiet
        @(posedge clk); #1;
        mem_r = 1'b1; addr = 32'h10; dmtype = 3'd2;
        e.d = 32'b0; e.m = 1'b0; e.l = 16'b0; e.nm = "reset";
        sbq.push_back(e);
        @(negedge clk);
        mem_r = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        for (int w = 0; w < 64; w++) do_access(1, 0, 32'(4 * w), 32'b0, 3'd2, "init");
        do_access(1, 0, 32'hFFC, 32'b0, 3'd2, "init_top");
        do_access(0, 1, BASE + 8, 0, 3'd2, "rst_status", 1, 32'b0, 0);
        do_access(0, 1, BASE + 12, 0, 3'd2, "rst_faddr", 1, 32'b0, 0);
        do_access(0, 1, BASE + 4, 0, 3'd2, "cycle_a");

        do_access(1, 0, 32'h10, 32'h8000_00F1, 3'd2, "t1_sw");
        do_access(0, 1, 32'h10, 0, 3'd0, "t1_lb", 1, 32'hFFFF_FFF1, 0);
        do_access(0, 1, 32'h13, 0, 3'd4, "t1_lbu", 1, 32'h0000_0080, 0);
        do_access(0, 1, 32'h12, 0, 3'd1, "t1_lh", 1, 32'hFFFF_8000, 0);
        do_access(0, 1, 32'h10, 0, 3'd2, "t1_lw", 1, 32'h8000_00F1, 0);
        for (int i = 0; i < 4; i++) begin
            do_access(0, 1, 32'h10 + 32'(i), 0, 3'd0, "t1_lb_m");
            do_access(0, 1, 32'h10 + 32'(i), 0, 3'd4, "t1_lbu_m");
            do_access(0, 1, 32'h10 + 32'(i & 2), 0, 3'd1, "t1_lh_m");
            do_access(0, 1, 32'h10 + 32'(i & 2), 0, 3'd5, "t1_lhu_m");
        end

        do_access(1, 0, 32'h20, 32'h1122_3344, 3'd2, "t2_sw");
        do_access(1, 0, 32'h21, 32'h0000_00AB, 3'd0, "t2_sb");
        do_access(1, 0, 32'h22, 32'h0000_BEEF, 3'd1, "t2_sh");
        do_access(0, 1, 32'h20, 0, 3'd2, "t2_lw", 1, 32'hBEEF_AB44, 0);

        do_access(1, 0, 32'h31, 32'hFFFF_FFFF, 3'd1, "t3_sh", 1, 32'b0, 1);
        do_access(0, 1, 32'h22, 0, 3'd2, "t3_lw", 1, 32'b0, 1);
        do_access(0, 1, 32'h30, 0, 3'd2, "t3_ram", 1, 32'b0, 0);
        do_access(0, 1, BASE + 8, 0, 3'd2, "t3_status", 1, 32'h1, 0);
        do_access(0, 1, BASE + 12, 0, 3'd2, "t3_faddr", 1, 32'h31, 0);
        do_access(1, 0, BASE + 8, 32'h7, 3'd2, "t3_clr");
        do_access(0, 1, BASE + 8, 0, 3'd2, "t3_clr_rd", 1, 32'h0, 0);

        do_access(0, 1, 32'h0010_0000, 0, 3'd2, "t4_oor", 1, 32'b0, 1);
        do_access(0, 1, BASE + 8, 0, 3'd2, "t4_status", 1, 32'h2, 0);
        do_access(1, 0, BASE + 8, 32'h7, 3'd2, "t4_clr");
        do_access(0, 1, BASE + 8, 0, 3'd2, "t4_clr_rd", 1, 32'h0, 0);
        do_access(0, 1, 32'h1000, 0, 3'd2, "t4_edge_oor", 1, 32'b0, 1);
        do_access(0, 1, 32'hFFC, 0, 3'd2, "t4_edge_ram", 1, 32'b0, 0);
        do_access(0, 1, BASE + 2, 0, 3'd1, "t4_mmio_half", 1, 32'b0, 1);
        do_access(1, 1, BASE + 8, 32'h7, 3'd2, "t4_clr_new");
        do_access(0, 1, BASE + 8, 0, 3'd2, "t4_clr_new_rd", 1, 32'h4, 0);
        do_access(1, 0, BASE + 8, 32'h7, 3'd2, "t4_clr2");

        do_access(1, 0, BASE, 32'h1234_5678, 3'd2, "t5_led_sw");
        do_access(0, 1, BASE, 0, 3'd2, "t5_led_rd", 1, 32'h0000_5678, 0);
        do_access(0, 1, BASE + 4, 0, 3'd2, "t5_cyc0");
        do_access(0, 1, BASE + 4, 0, 3'd2, "t5_cyc1");
        do_access(0, 0, 0, 0, 3'd0, "t5_idle");
        #1;
        force dut.cycle = 32'hFFFF_FFFD;
        #1;
        release dut.cycle;
        cyc_adj = 32'hFFFF_FFFD - edges;
        do_access(0, 1, BASE + 4, 0, 3'd2, "t5_wrap0", 1, 32'hFFFF_FFFE, 0);
        do_access(0, 1, BASE + 4, 0, 3'd2, "t5_wrap1", 1, 32'hFFFF_FFFF, 0);
        do_access(0, 1, BASE + 4, 0, 3'd2, "t5_wrap2", 1, 32'h0000_0000, 0);

        do_access(1, 1, 32'h40, 32'hCAFE_F00D, 3'd2, "t6_rwc", 1, 32'b0, 0);
        do_access(0, 1, 32'h40, 0, 3'd2, "t6_rwc_rd", 1, 32'hCAFE_F00D, 0);
        do_access(0, 1, BASE + 8, 0, 3'd2, "t6_status", 1, 32'h4, 0);

        // Reset raised between edges while a store is on the bus
        @(posedge clk); #1;
        mem_w = 1'b1; mem_r = 1'b0; addr = 32'h44; din = 32'hDEAD_BEEF; dmtype = 3'd2;
        #2;
        reset = 1'b1;
        m_led = 16'b0; m_st = 3'b0; m_fa = 32'b0; cyc_adj = 32'b0;
        e.d = 32'b0; e.m = 1'b0; e.l = 16'b0; e.nm = "t6_async_rst";
        sbq.push_back(e);
        @(posedge clk); #1;
        mem_w = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        do_access(0, 1, 32'h44, 0, 3'd2, "t6_lost", 1, 32'b0, 0);
        do_access(0, 1, BASE + 8, 0, 3'd2, "t6_st0", 1, 32'b0, 0);
        do_access(0, 1, BASE + 4, 0, 3'd2, "t6_cyc");

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      a = 32'($urandom_range(0, 255));
            else if (r == 6) a = 32'($urandom_range(4092, 4095));
            else if (r == 7) a = BASE + 32'($urandom_range(0, 15));
            else if (r == 8) a = $urandom | 32'h0001_0000;
            else             a = 32'h1000 + 32'($urandom_range(0, 63));
            do_access($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, $urandom,
                      ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                  : legal_t[$urandom_range(0, 4)],
                      "rand");
        end
        do_access(0, 1, BASE + 8, 0, 3'd2, "rand_status");
        do_access(0, 1, BASE + 12, 0, 3'd2, "rand_faddr");
        do_access(0, 0, 0, 0, 3'd0, "final_idle");

        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
